csr_trap_unit: RTL and testbench
================================

// Module: csr_trap_unit
// PURPOSE
//  Machine-mode CSR file and trap sequencer, downstream of history_file.
//  Consumes the precise-exception report (exc_occured/mepc/mcause/mtval) after recovery.
//  Latches the trap CSRs and redirects fetch to mtvec.
//  Also executes CSRRW/CSRRS/CSRRC from the pipeline and MRET returns.
// PARAMETERS
//  RESET_MTVEC  32'h0000_0000  reset value of mtvec (direct mode, bits[1:0] forced 00)
//  XLEN         32             data width; only 32 is supported
// PORTS
//  clk_i            in   1   clock; all state updates on posedge
//  rsn_i            in   1   asynchronous active-low reset
//  exc_occured_i    in   1   1-cycle pulse from history_file: precise trap
//  exc_mepc_i       in   32  faulting PC
//  exc_mcause_i     in   32  cause code
//  exc_mtval_i      in   32  miss address / trap value
//  mret_i           in   1   1-cycle pulse: MRET reached commit
//  csr_valid_i      in   1   CSR instruction request
//  csr_op_i         in   2   01=RW 10=RS 11=RC; 00 = read only, no write
//  csr_addr_i       in   12  CSR address
//  csr_wdata_i      in   32  rs1 / uimm operand
//  csr_rvalid_o     out  1   rdata valid, 1 cycle after accepted request
//  csr_rdata_o      out  32  old CSR value (read-before-write)
//  csr_illegal_o    out  1   1-cycle pulse: unimplemented address
//  busy_o           out  1   FSM not IDLE; upstream must hold CSR/MRET requests
//  redirect_valid_o out  1   1-cycle pulse: flush and fetch redirect_pc_o
//  redirect_pc_o    out  32  trap vector or return PC
//  mie_o            out  1   mstatus.MIE, for interrupt gating
// BEHAVIOUR
//  Reset (async, rsn_i=0): FSM=IDLE; mstatus=32'h0000_1800 (MPP=11, MIE=MPIE=0).
//   mtvec=RESET_MTVEC; mepc/mcause/mtval/mscratch=0.
//   All outputs 0. Reset mid-trap abandons the redirect; no pulse is emitted.
//  CSR map: 300 mstatus (only MIE[3], MPIE[7] writable; MPP reads 11, other bits 0).
//   305 mtvec (bits[1:0] read 0); 340 mscratch.
//   341 mepc (bits[1:0] read 0); 342 mcause; 343 mtval.
//  FSM states: IDLE, TRAP, MRET; TRAP and MRET each last exactly 1 cycle, then return to IDLE.
//  IDLE + exc_occured_i -> TRAP.
//   Posedge: mepc<=exc_mepc_i&~3, mcause, mtval latched; MPIE<=MIE; MIE<=0.
//   In TRAP: redirect_valid_o=1, redirect_pc_o=mtvec, busy_o=1.
//  IDLE + mret_i (no exc) -> MRET.
//   Posedge: MIE<=MPIE, MPIE<=1.
//   In MRET: redirect_valid_o=1, redirect_pc_o=mepc, busy_o=1.
//  CSR access is accepted in IDLE only when no exc_occured_i or mret_i is present that cycle.
//   Next cycle: csr_rvalid_o=1, csr_rdata_o=old value; the write takes effect at the same posedge.
//   RW: new=wdata. RS: new=old|wdata. RC: new=old&~wdata. op 00: no write.
//   Writes obey the per-register masks above.
//  Unimplemented address: csr_illegal_o=1 alongside csr_rvalid_o=1, csr_rdata_o=0, no state change.
//  Priority when simultaneous in IDLE: exc_occured_i > mret_i > csr_valid_i.
//   Lower-priority requests that cycle are dropped, not queued; the killed instruction is never committed.
//  Requests arriving while busy_o=1 are ignored; the protocol forbids them.
//  A CSR write of mtvec/mepc in cycle N is visible to a trap/MRET accepted in cycle N+1.
// CONFIGURATION
//  CSR_COUNTERS_EN defined:
//   Adds mcycle B00/mcycleh B80 and minstret B02/minstreth B82 (64-bit, reset 0).
//   Adds input retire_i (1 bit) to the port list.
//   mcycle increments every cycle. minstret increments when retire_i=1.
//   A CSR write to either half overrides the increment in that cycle.
//   Low word wraps FFFF_FFFF->0 and carries into the high word.
//  Not defined: counters and retire_i are absent; B00/B02/B80/B82 raise csr_illegal_o.
// TESTING
//  Reset, then read 300 -> rdata 0000_1800; read 305 -> RESET_MTVEC; no redirect pulse.
//  RW 305<=0000_0103, then exc(mepc=0000_0046, mcause=2, mtval=DEAD_BEEF) ->
//   next cycle redirect to 0000_0100; mepc reads 0000_0044; mcause 2; mtval DEAD_BEEF.
//  RS 300<=0000_0008 (MIE=1), trap, MRET -> after trap mstatus=0000_1880;
//   MRET redirects to mepc; mstatus=0000_1888.
//  exc_occured_i, mret_i and csr_valid_i (RW 340<=1234) in the same cycle ->
//   only trap redirect occurs; mscratch stays 0.
//  csr_valid_i addr 7C0 -> csr_illegal_o=1, rdata 0; CSR state unchanged.
//  CSR_COUNTERS_EN: write mcycle=FFFF_FFFE, mcycleh=0 -> two cycles later mcycleh reads 1.
//   retire_i held 0 -> minstret unchanged.

Source files
------------

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the pipeline (master) and the CSR/trap unit (slave).
// The pipeline issues one request per cycle; the unit answers one cycle later
// with the old register value, or with an illegal-address flag.
//   csr_valid_i    request strobe
//   csr_op_i       01=RW 10=RS 11=RC 00=read only
//   csr_addr_i     12-bit CSR address
//   csr_wdata_i    rs1 / uimm operand
//   csr_rvalid_o   response strobe, one cycle after an accepted request
//   csr_rdata_o    value of the CSR before the write
//   csr_illegal_o  response is for an unimplemented address
interface csr_trap_unit_if;
   logic        csr_valid_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;

   modport master (
      output csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  csr_rvalid_o, csr_rdata_o, csr_illegal_o
   );

   modport slave (
      input  csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output csr_rvalid_o, csr_rdata_o, csr_illegal_o
   );
endinterface

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer.
// Takes the precise-exception report from history_file, latches the trap CSRs
// and redirects fetch to mtvec; executes CSRRW/CSRRS/CSRRC and MRET.
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret and the
// retire_i input.
// Ports:
//   clk_i, rsn_i          clock, asynchronous active-low reset
//   exc_occured_i         1-cycle precise trap pulse with exc_mepc_i/exc_mcause_i/exc_mtval_i
//   mret_i                1-cycle pulse, MRET reached commit
//   retire_i              (CSR_COUNTERS_EN only) one instruction retired this cycle
//   csr                   CSR access bus (slave side)
//   busy_o                unit is sequencing a trap/return; upstream holds requests
//   redirect_valid_o      1-cycle flush + fetch redirect to redirect_pc_o
//   mie_o                 mstatus.MIE for interrupt gating
module csr_trap_unit #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter int          XLEN        = 32
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              exc_occured_i,
   input  logic [XLEN-1:0]   exc_mepc_i,
   input  logic [XLEN-1:0]   exc_mcause_i,
   input  logic [XLEN-1:0]   exc_mtval_i,
   input  logic              mret_i,
`ifdef CSR_COUNTERS_EN
   input  logic              retire_i,
`endif
   csr_trap_unit_if.slave    csr,
   output logic              busy_o,
   output logic              redirect_valid_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              mie_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRAP,
      S_MRET
   } state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

   state_t state, state_next;

   logic            mie, mpie;
   logic [XLEN-1:0] mtvec, mepc, mcause, mtval, mscratch;

`ifdef CSR_COUNTERS_EN
   logic [63:0]     mcycle, minstret;
`endif

   logic            trap_take, mret_take, csr_accept, csr_write, addr_legal;
   logic [XLEN-1:0] old_val, new_val;

   logic            rvalid_q, illegal_q;
   logic [XLEN-1:0] rdata_q;

   // Arbitration: a trap wins over MRET, which wins over a CSR access; losers
   // are dropped because the pipeline flushes them anyway.
   assign trap_take  = (state == S_IDLE) && exc_occured_i;
   assign mret_take  = (state == S_IDLE) && !exc_occured_i && mret_i;
   assign csr_accept = (state == S_IDLE) && !exc_occured_i && !mret_i && csr.csr_valid_i;
   assign csr_write  = csr_accept && addr_legal && (csr.csr_op_i != 2'b00);

   // Read mux: old value of the addressed CSR, plus legality decode.
   // mstatus shows MPP hard-wired to 11 alongside the two live enable bits.
   always_comb begin
      old_val    = '0;
      addr_legal = 1'b1;
      case (csr.csr_addr_i)
         12'h300: old_val = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
         12'h305: old_val = mtvec;
         12'h340: old_val = mscratch;
         12'h341: old_val = mepc;
         12'h342: old_val = mcause;
         12'h343: old_val = mtval;
`ifdef CSR_COUNTERS_EN
         12'hB00: old_val = mcycle[31:0];
         12'hB80: old_val = mcycle[63:32];
         12'hB02: old_val = minstret[31:0];
         12'hB82: old_val = minstret[63:32];
`endif
         default: addr_legal = 1'b0;
      endcase
   end

   // Write value for the three CSR instruction flavours.
   always_comb begin
      new_val = old_val;
      case (csr.csr_op_i)
         2'b01:   new_val = csr.csr_wdata_i;
         2'b10:   new_val = old_val | csr.csr_wdata_i;
         2'b11:   new_val = old_val & ~csr.csr_wdata_i;
         default: new_val = old_val;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and redirect outputs; TRAP and MRET are single-cycle states
   // that present the redirect and then fall back to IDLE.
   always_comb begin
      state_next       = state;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      busy_o           = 1'b0;
      case (state)
         S_IDLE: begin
            if (trap_take) begin
               state_next = S_TRAP;
            end else if (mret_take) begin
               state_next = S_MRET;
            end
         end
         S_TRAP: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = mtvec;
            busy_o           = 1'b1;
            state_next       = S_IDLE;
         end
         S_MRET: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = mepc;
            busy_o           = 1'b1;
            state_next       = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Architectural CSR state. Trap entry stacks MIE into MPIE; MRET unstacks it.
   // CSR writes cannot coincide with either because acceptance excludes them.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= RESET_MTVEC & ALIGN_MASK;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
         mscratch <= '0;
      end else if (trap_take) begin
         mepc   <= exc_mepc_i & ALIGN_MASK;
         mcause <= exc_mcause_i;
         mtval  <= exc_mtval_i;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_take) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (csr_write) begin
         case (csr.csr_addr_i)
            12'h300: begin
               mie  <= new_val[3];
               mpie <= new_val[7];
            end
            12'h305: mtvec    <= new_val & ALIGN_MASK;
            12'h340: mscratch <= new_val;
            12'h341: mepc     <= new_val & ALIGN_MASK;
            12'h342: mcause   <= new_val;
            12'h343: mtval    <= new_val;
            default: ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   // Free-running counters; a write to either half replaces the whole
   // increment for that cycle, leaving the other half untouched.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (csr_write && csr.csr_addr_i == 12'hB00) begin
            mcycle[31:0] <= new_val;
         end else if (csr_write && csr.csr_addr_i == 12'hB80) begin
            mcycle[63:32] <= new_val;
         end else begin
            mcycle <= mcycle + 64'd1;
         end

         if (csr_write && csr.csr_addr_i == 12'hB02) begin
            minstret[31:0] <= new_val;
         end else if (csr_write && csr.csr_addr_i == 12'hB82) begin
            minstret[63:32] <= new_val;
         end else if (retire_i) begin
            minstret <= minstret + 64'd1;
         end
      end
   end
`endif

   // Response register: read-before-write data one cycle after acceptance;
   // unimplemented addresses answer zero with the illegal flag.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         rvalid_q  <= 1'b0;
         illegal_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rvalid_q  <= csr_accept;
         illegal_q <= csr_accept && !addr_legal;
         rdata_q   <= (csr_accept && addr_legal) ? old_val : '0;
      end
   end

   assign csr.csr_rvalid_o  = rvalid_q;
   assign csr.csr_illegal_o = illegal_q;
   assign csr.csr_rdata_o   = rdata_q;
   assign mie_o             = mie;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed self-checking bench for csr_trap_unit.
// Expected values are hand-computed from the CSR map and trap semantics.
// Build with +define+CSR_COUNTERS_EN to also exercise the counters.
module tb_csr_trap_unit;

   logic        clk;
   logic        rsn;
   logic        exc;
   logic [31:0] excMepc, excMcause, excMtval;
   logic        mret;
   logic        retire;
   logic        busy, redirectValid, mieOut;
   logic [31:0] redirectPc;

   int checkCount = 0;
   int passCount  = 0;

   csr_trap_unit_if csrBus ();

   csr_trap_unit #(
      .RESET_MTVEC (32'h0000_0000),
      .XLEN        (32)
   ) dut (
      .clk_i            (clk),
      .rsn_i            (rsn),
      .exc_occured_i    (exc),
      .exc_mepc_i       (excMepc),
      .exc_mcause_i     (excMcause),
      .exc_mtval_i      (excMtval),
      .mret_i           (mret),
`ifdef CSR_COUNTERS_EN
      .retire_i         (retire),
`endif
      .csr              (csrBus.slave),
      .busy_o           (busy),
      .redirect_valid_o (redirectValid),
      .redirect_pc_o    (redirectPc),
      .mie_o            (mieOut)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %08h, want %08h", tag, observed, expected);
      end
   endtask

   // One CSR request; the response is sampled 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                                input string tag, input logic [31:0] expRdata, input logic expIllegal);
      csrBus.csr_valid_i = 1'b1;
      csrBus.csr_op_i    = op;
      csrBus.csr_addr_i  = addr;
      csrBus.csr_wdata_i = wdata;
      @(posedge clk);
      #1;
      csrBus.csr_valid_i = 1'b0;
      checkOutput({tag, " rvalid"}, {31'b0, csrBus.csr_rvalid_o}, 32'd1);
      checkOutput({tag, " rdata"}, csrBus.csr_rdata_o, expRdata);
      checkOutput({tag, " illegal"}, {31'b0, csrBus.csr_illegal_o}, {31'b0, expIllegal});
   endtask

   // Trap pulse; leaves the bench sampling inside the TRAP cycle.
   task automatic pulseTrap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
      exc       = 1'b1;
      excMepc   = pc;
      excMcause = cause;
      excMtval  = tval;
      @(posedge clk);
      #1;
      exc = 1'b0;
   endtask

   // MRET pulse; leaves the bench sampling inside the MRET cycle.
   task automatic pulseMret();
      mret = 1'b1;
      @(posedge clk);
      #1;
      mret = 1'b0;
   endtask

   // Check a redirect cycle, then step back to IDLE and confirm the pulse ended.
   task automatic checkRedirect(input string tag, input logic [31:0] expPc);
      checkOutput({tag, " redirect_valid"}, {31'b0, redirectValid}, 32'd1);
      checkOutput({tag, " redirect_pc"}, redirectPc, expPc);
      checkOutput({tag, " busy"}, {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, " pulse end"}, {31'b0, redirectValid}, 32'd0);
      checkOutput({tag, " busy end"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rsn                = 1'b0;
      exc                = 1'b0;
      excMepc            = '0;
      excMcause          = '0;
      excMtval           = '0;
      mret               = 1'b0;
      retire             = 1'b0;
      csrBus.csr_valid_i = 1'b0;
      csrBus.csr_op_i    = 2'b00;
      csrBus.csr_addr_i  = '0;
      csrBus.csr_wdata_i = '0;

      #2;
      checkOutput("reset redirect_valid", {31'b0, redirectValid}, 32'd0);
      checkOutput("reset redirect_pc", redirectPc, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset mie", {31'b0, mieOut}, 32'd0);
      checkOutput("reset rvalid", {31'b0, csrBus.csr_rvalid_o}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rsn = 1'b1;

      // Reset values.
      applyStimulus(2'b00, 12'h300, 32'h0, "rd mstatus", 32'h0000_1800, 1'b0);
      checkOutput("no redirect after reset", {31'b0, redirectValid}, 32'd0);
      applyStimulus(2'b00, 12'h305, 32'h0, "rd mtvec", 32'h0000_0000, 1'b0);

      // Trap to a written vector; low mtvec/mepc bits are dropped.
      applyStimulus(2'b01, 12'h305, 32'h0000_0103, "rw mtvec", 32'h0000_0000, 1'b0);
      pulseTrap(32'h0000_0046, 32'd2, 32'hDEAD_BEEF);
      checkRedirect("trap1", 32'h0000_0100);
      applyStimulus(2'b00, 12'h341, 32'h0, "rd mepc", 32'h0000_0044, 1'b0);
      applyStimulus(2'b00, 12'h342, 32'h0, "rd mcause", 32'h0000_0002, 1'b0);
      applyStimulus(2'b00, 12'h343, 32'h0, "rd mtval", 32'hDEAD_BEEF, 1'b0);
      applyStimulus(2'b00, 12'h305, 32'h0, "rd mtvec masked", 32'h0000_0100, 1'b0);

      // MIE stacking through trap and MRET.
      applyStimulus(2'b10, 12'h300, 32'h0000_0008, "rs mstatus", 32'h0000_1800, 1'b0);
      checkOutput("mie set", {31'b0, mieOut}, 32'd1);
      applyStimulus(2'b00, 12'h300, 32'h0, "rd mstatus mie", 32'h0000_1808, 1'b0);
      pulseTrap(32'h0000_0200, 32'd3, 32'h0);
      checkRedirect("trap2", 32'h0000_0100);
      applyStimulus(2'b00, 12'h300, 32'h0, "rd mstatus trap", 32'h0000_1880, 1'b0);
      checkOutput("mie after trap", {31'b0, mieOut}, 32'd0);
      pulseMret();
      checkRedirect("mret1", 32'h0000_0200);
      applyStimulus(2'b00, 12'h300, 32'h0, "rd mstatus mret", 32'h0000_1888, 1'b0);
      checkOutput("mie after mret", {31'b0, mieOut}, 32'd1);

      // Trap, MRET and CSR write together: only the trap happens.
      exc                = 1'b1;
      excMepc            = 32'h0000_0300;
      excMcause          = 32'd5;
      excMtval           = 32'h0;
      mret               = 1'b1;
      csrBus.csr_valid_i = 1'b1;
      csrBus.csr_op_i    = 2'b01;
      csrBus.csr_addr_i  = 12'h340;
      csrBus.csr_wdata_i = 32'h0000_1234;
      @(posedge clk);
      #1;
      exc                = 1'b0;
      mret               = 1'b0;
      csrBus.csr_valid_i = 1'b0;
      checkOutput("collide no rvalid", {31'b0, csrBus.csr_rvalid_o}, 32'd0);
      checkRedirect("collide", 32'h0000_0100);
      applyStimulus(2'b00, 12'h340, 32'h0, "rd mscratch dropped", 32'h0000_0000, 1'b0);
      applyStimulus(2'b00, 12'h342, 32'h0, "rd mcause collide", 32'h0000_0005, 1'b0);

      // Unimplemented addresses.
      applyStimulus(2'b01, 12'h7C0, 32'hFFFF_FFFF, "illegal 7c0", 32'h0, 1'b1);
`ifndef CSR_COUNTERS_EN
      applyStimulus(2'b00, 12'hB00, 32'h0, "illegal b00", 32'h0, 1'b1);
`endif

      // RW / RC / RS / read-only sequence on mscratch.
      applyStimulus(2'b01, 12'h340, 32'h0000_F0F0, "rw mscratch", 32'h0000_0000, 1'b0);
      applyStimulus(2'b11, 12'h340, 32'h0000_00F0, "rc mscratch", 32'h0000_F0F0, 1'b0);
      applyStimulus(2'b10, 12'h340, 32'h0000_0001, "rs mscratch", 32'h0000_F000, 1'b0);
      applyStimulus(2'b00, 12'h340, 32'h0000_FFFF, "op00 mscratch", 32'h0000_F001, 1'b0);
      applyStimulus(2'b00, 12'h340, 32'h0, "rd mscratch", 32'h0000_F001, 1'b0);

      // mstatus write mask.
      applyStimulus(2'b01, 12'h300, 32'hFFFF_FFFF, "rw mstatus ones", 32'h0000_1880, 1'b0);
      applyStimulus(2'b00, 12'h300, 32'h0, "rd mstatus mask", 32'h0000_1888, 1'b0);

      // mepc written one cycle before MRET is the return target.
      applyStimulus(2'b01, 12'h341, 32'h0000_0207, "rw mepc", 32'h0000_0300, 1'b0);
      pulseMret();
      checkRedirect("mret2", 32'h0000_0204);

      // Reset in the middle of a trap abandons the redirect.
      pulseTrap(32'h0000_0010, 32'd7, 32'h0);
      checkOutput("pre-reset redirect", {31'b0, redirectValid}, 32'd1);
      #1;
      rsn = 1'b0;
      #1;
      checkOutput("midtrap reset redirect", {31'b0, redirectValid}, 32'd0);
      checkOutput("midtrap reset busy", {31'b0, busy}, 32'd0);
      checkOutput("midtrap reset mie", {31'b0, mieOut}, 32'd0);
      @(posedge clk);
      #1;
      rsn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post reset redirect", {31'b0, redirectValid}, 32'd0);
      applyStimulus(2'b00, 12'h305, 32'h0, "rd mtvec reset", 32'h0000_0000, 1'b0);
      applyStimulus(2'b00, 12'h341, 32'h0, "rd mepc reset", 32'h0000_0000, 1'b0);
      applyStimulus(2'b00, 12'h340, 32'h0, "rd mscratch reset", 32'h0000_0000, 1'b0);

`ifdef CSR_COUNTERS_EN
      // Low-word wrap carries into the high word.
      applyStimulus(2'b01, 12'hB00, 32'hFFFF_FFFE, "rw mcycle", 32'h0, 1'b0);
      applyStimulus(2'b01, 12'hB80, 32'h0000_0000, "rw mcycleh", 32'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 12'hB80, 32'h0, "rd mcycleh carry", 32'h0000_0001, 1'b0);
      // minstret holds while nothing retires.
      retire = 1'b0;
      applyStimulus(2'b01, 12'hB02, 32'h0000_0005, "rw minstret", 32'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 12'hB02, 32'h0, "rd minstret hold", 32'h0000_0005, 1'b0);
      retire = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      retire = 1'b0;
      applyStimulus(2'b00, 12'hB02, 32'h0, "rd minstret retire", 32'h0000_0007, 1'b0);
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
